fetch_unit: RTL and testbench

Instruction fetch front-end that sits directly upstream of the single-cycle datapath. It owns the fetch PC and issues word reads to a synchronous instruction memory. Returned instructions go into a 4-entry prefetch FIFO, and the FIFO head is presented to the decode/execute stage over a valid/ready handshake. The execute stage redirects fetch on taken branches, JMP, JSR and JSRR, and the redirect flushes all prefetched and in-flight instructions.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues word reads to a synchronous
// instruction memory and queues returned instructions in a show-ahead prefetch FIFO.
module fetch_unit #(
    parameter  int PC_WIDTH   = 16,
    parameter  int INST_WIDTH = 32,
    parameter  int IMEM_AW    = 6,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lock,
    output logic                  o_imem_req,
    output logic [IMEM_AW-1:0]    o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    input  logic                  i_redirect_valid,
    input  logic [PC_WIDTH-1:0]   i_redirect_pc,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [INST_WIDTH-1:0] o_inst_data,
    output logic [PC_WIDTH-1:0]   o_inst_pc,
    output logic [CNT_W-1:0]      o_fifo_count
);

    logic [PC_WIDTH-1:0]   r_fetchPc;
    logic [PC_WIDTH-1:0]   r_pendingPc;
    logic                  r_pending;
    logic                  r_pendingEpoch;
    logic                  r_epoch;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [CNT_W-1:0]      r_count;
    logic [PC_WIDTH-1:0]   r_memPc   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] r_memInst [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   r_headPc;
    logic [INST_WIDTH-1:0] r_headInst;

    logic                  w_redirect;
    logic [CNT_W:0]        w_inFlight;
    logic                  w_req;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_nextCount;
    logic [PTR_W-1:0]      w_nextRdPtr;
    logic [PC_WIDTH-1:0]   w_nextHeadPc;
    logic [INST_WIDTH-1:0] w_nextHeadInst;
    logic                  w_unusedPcBits;

    assign w_unusedPcBits = &{1'b0, i_redirect_pc[1:0]};

    // Occupancy uses the registered count, so a same-cycle pop does not free a slot early.
    assign w_redirect = i_lock & i_redirect_valid;
    assign w_inFlight = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pending};
    assign w_req      = i_rst_n & i_lock & ~i_redirect_valid
                      & (w_inFlight < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_push     = r_pending & (r_pendingEpoch == r_epoch) & ~w_redirect;
    assign w_pop      = (r_count != '0) & i_inst_ready & ~w_redirect;

    assign w_nextRdPtr = w_pop ? r_rdPtr + PTR_W'(1) : r_rdPtr;

    always_comb begin
        w_nextCount = r_count;
        if (w_redirect) begin
            w_nextCount = '0;
        end else if (w_push && !w_pop) begin
            w_nextCount = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_nextCount = r_count - CNT_W'(1);
        end
    end

    // Head is registered so it holds its last value while the FIFO is empty.
    always_comb begin
        w_nextHeadPc   = r_headPc;
        w_nextHeadInst = r_headInst;
        if (w_nextCount != '0) begin
            if (w_push && (w_nextCount == CNT_W'(1))) begin
                w_nextHeadPc   = r_pendingPc;
                w_nextHeadInst = i_imem_rdata;
            end else begin
                w_nextHeadPc   = r_memPc[w_nextRdPtr];
                w_nextHeadInst = r_memInst[w_nextRdPtr];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetchPc      <= '0;
            r_pendingPc    <= '0;
            r_pending      <= 1'b0;
            r_pendingEpoch <= 1'b0;
            r_epoch        <= 1'b0;
            r_rdPtr        <= '0;
            r_wrPtr        <= '0;
            r_count        <= '0;
            r_headPc       <= '0;
            r_headInst     <= '0;
        end else begin
            r_count    <= w_nextCount;
            r_headPc   <= w_nextHeadPc;
            r_headInst <= w_nextHeadInst;
            r_pending  <= w_req;
            if (w_req) begin
                r_pendingPc    <= r_fetchPc;
                r_pendingEpoch <= r_epoch;
            end
            if (w_redirect) begin
                r_rdPtr   <= '0;
                r_wrPtr   <= '0;
                r_epoch   <= ~r_epoch;
                r_fetchPc <= {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                if (w_req) begin
                    r_fetchPc <= r_fetchPc + PC_WIDTH'(4);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_memPc[r_wrPtr]   <= r_pendingPc;
            r_memInst[r_wrPtr] <= i_imem_rdata;
        end
    end

    assign o_imem_req   = w_req;
    assign o_imem_addr  = r_fetchPc[IMEM_AW+1:2];
    assign o_inst_valid = (r_count != '0);
    assign o_inst_data  = r_headInst;
    assign o_inst_pc    = r_headPc;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, inst} pairs, a monitor
// pops and compares on every accepted handshake; directed checks cover timing corners.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;
    logic        imemReq;
    logic [5:0]  imemAddr;
    logic [31:0] imemRdata = '0;
    logic        redirectValid = 1'b0;
    logic [15:0] redirectPc = '0;
    logic        instValid;
    logic        instReady = 1'b0;
    logic [31:0] instData;
    logic [15:0] instPc;
    logic [2:0]  fifoCount;

    logic        reqS = 1'b0;
    logic [5:0]  addrS = '0;

    logic [47:0] expQ[$];
    int errors = 0;
    int checks = 0;
    int popCount = 0;

    fetch_unit #(
        .PC_WIDTH(16), .INST_WIDTH(32), .IMEM_AW(6), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_lock(lock),
        .o_imem_req(imemReq),
        .o_imem_addr(imemAddr),
        .i_imem_rdata(imemRdata),
        .i_redirect_valid(redirectValid),
        .i_redirect_pc(redirectPc),
        .o_inst_valid(instValid),
        .i_inst_ready(instReady),
        .o_inst_data(instData),
        .o_inst_pc(instPc),
        .o_fifo_count(fifoCount)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word n holds 0x1000_0000 + n.
    always @(negedge clk) begin
        reqS  <= imemReq;
        addrS <= imemAddr;
    end

    always @(posedge clk) begin
        if (reqS) begin
            imemRdata <= 32'h1000_0000 + {26'd0, addrS};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [47:0] e;
        if (rst_n && instValid && instReady) begin
            popCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got pc 0x%0h expected no output", instPc);
            end else begin
                e = expQ.pop_front();
                checkOutput("pop_pc", {16'd0, instPc}, {16'd0, e[47:32]});
                checkOutput("pop_data", instData, e[31:0]);
            end
        end
    end

    task automatic expectRun(input logic [15:0] startPc, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] pc;
            pc = startPc + 16'(4 * i);
            expQ.push_back({pc, 32'h1000_0000 + {26'd0, pc[7:2]}});
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic rv, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        lock          = l;
        instReady     = r;
        redirectValid = rv;
        redirectPc    = rpc;
    endtask

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, 32'(instValid), 32'd0);
        checkOutput({tag, "_count"}, 32'(fifoCount), 32'd0);
        checkOutput({tag, "_data"}, instData, 32'd0);
        checkOutput({tag, "_pc"}, 32'(instPc), 32'd0);
        checkOutput({tag, "_req"}, 32'(imemReq), 32'd0);
        checkOutput({tag, "_addr"}, 32'(imemAddr), 32'd0);
    endtask

    // Holds reset for two cycles, then releases it just after a rising edge.
    task automatic doReset(input logic l, input logic r);
        rst_n         = 1'b0;
        lock          = 1'b0;
        instReady     = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("rst");
        expQ.delete();
        popCount = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        lock      = l;
        instReady = r;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Streaming from reset with ready held high.
        doReset(1'b1, 1'b1);
        expectRun(16'h0000, 40);
        waitNeg();
        checkOutput("t1_req_c0", 32'(imemReq), 32'd1);
        checkOutput("t1_addr_c0", 32'(imemAddr), 32'd0);
        checkOutput("t1_valid_c0", 32'(instValid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t1_valid_c1", 32'(instValid), 32'd0);
        checkOutput("t1_addr_c1", 32'(imemAddr), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t1_valid_c2", 32'(instValid), 32'd1);
        checkOutput("t1_pc_c2", 32'(instPc), 32'd0);
        repeat (11) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t1_popcount", 32'(popCount), 32'd12);

        // FIFO fills with ready low, then drains in order and fetch resumes at 16.
        doReset(1'b1, 1'b0);
        expectRun(16'h0000, 40);
        waitNeg();
        repeat (7) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
            waitNeg();
        end
        checkOutput("t2_req_full", 32'(imemReq), 32'd0);
        checkOutput("t2_count_full", 32'(fifoCount), 32'd4);
        checkOutput("t2_valid_full", 32'(instValid), 32'd1);
        checkOutput("t2_headpc_full", 32'(instPc), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t2_req_drain0", 32'(imemReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t2_req_resume", 32'(imemReq), 32'd1);
        checkOutput("t2_addr_resume", 32'(imemAddr), 32'd4);
        repeat (10) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t2_popcount", 32'(popCount), 32'd12);

        // Redirect with two entries queued and one request in flight.
        doReset(1'b1, 1'b0);
        waitNeg();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0042);
        waitNeg();
        checkOutput("t3_count_pre", 32'(fifoCount), 32'd2);
        checkOutput("t3_req_redirect", 32'(imemReq), 32'd0);
        expectRun(16'h0040, 20);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t3_valid_r1", 32'(instValid), 32'd0);
        checkOutput("t3_count_r1", 32'(fifoCount), 32'd0);
        checkOutput("t3_req_r1", 32'(imemReq), 32'd1);
        checkOutput("t3_addr_r1", 32'(imemAddr), 32'h10);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t3_valid_r2", 32'(instValid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t3_valid_r3", 32'(instValid), 32'd1);
        checkOutput("t3_pc_r3", 32'(instPc), 32'h40);
        repeat (6) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t3_popcount", 32'(popCount), 32'd7);

        // lock low for three cycles mid-stream, with an ignored redirect pulse.
        doReset(1'b1, 1'b1);
        expectRun(16'h0000, 40);
        waitNeg();
        repeat (5) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t4_req_lock_a", 32'(imemReq), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0080);
        waitNeg();
        checkOutput("t4_req_lock_b", 32'(imemReq), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t4_req_lock_c", 32'(imemReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t4_req_resume", 32'(imemReq), 32'd1);
        checkOutput("t4_addr_resume", 32'(imemAddr), 32'd6);
        repeat (6) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t4_popcount", 32'(popCount), 32'd11);

        // Fetch address wraps at 256 bytes while inst_pc keeps counting.
        doReset(1'b1, 1'b0);
        waitNeg();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h00FC);
        waitNeg();
        checkOutput("t5_req_redirect", 32'(imemReq), 32'd0);
        expectRun(16'h00FC, 20);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t5_addr_a", 32'(imemAddr), 32'h3F);
        checkOutput("t5_valid_r1", 32'(instValid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t5_addr_b", 32'(imemAddr), 32'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t5_pc_r3", 32'(instPc), 32'hFC);
        repeat (4) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t5_popcount", 32'(popCount), 32'd5);

        // Reset asserted mid-operation with three entries queued.
        doReset(1'b1, 1'b0);
        waitNeg();
        repeat (4) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
            waitNeg();
        end
        checkOutput("t6_count_pre", 32'(fifoCount), 32'd3);
        checkOutput("t6_data_pre", instData, 32'h1000_0000);
        rst_n = 1'b0;
        #1;
        checkResetValues("t6_async");
        doReset(1'b1, 1'b1);
        expectRun(16'h0000, 20);
        waitNeg();
        checkOutput("t6_valid_c0", 32'(instValid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t6_valid_c1", 32'(instValid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t6_valid_c2", 32'(instValid), 32'd1);
        checkOutput("t6_pc_c2", 32'(instPc), 32'd0);
        repeat (3) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            waitNeg();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        waitNeg();
        checkOutput("t6_popcount", 32'(popCount), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
